uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
Serial receiver for the 8N1 frame produced by the team's UART transmitter: 16 clocks per bit, LSB first, idle-high line.
- Synchronises the line, validates the start bit, samples data at mid-bit and checks the stop bit.
- Delivers each byte through a 2-entry output buffer with a valid/ready handshake.
- Sits between the pad-side serial input and the host-side byte consumer.

Parameters:
CLKS_PER_BIT, 16, sys_clk cycles per bit cell; must be even and ≥4
DATA_BITS, 8, data bits per frame, LSB first
HALF_BIT, CLKS_PER_BIT/2, cycles from detected start edge to start-bit confirm sample

Ports:
sys_clk  in  1  single clock; all state updates on its rising edge
sys_rst  in  1  synchronous reset, active-high
uart_rx_dataH  in  1  asynchronous serial line, idle 1
rx_dataH  out  DATA_BITS  head-of-buffer byte; valid while rx_validH=1
rx_validH  out  1  buffer non-empty
rx_readyH  in  1  consumer accepts when rx_validH&rx_readyH
frame_errH  out  1  one-cycle pulse: stop bit sampled 0
overrunH  out  1  one-cycle pulse: good frame dropped, buffer full
busyH  out  1  FSM not in IDLE

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; clock port sys_clk, reset port sys_rst.
- Reset values:
  - All outputs 0 (rx_dataH=0).
  - Buffer empty; FSM in IDLE.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame and the byte is lost. No pulse is generated in the reset cycle.
- Synchroniser: 2 flops. line_s is the second flop. FSM acts on line_s only.
- Counters:
  - cell_cnt: log2(CLKS_PER_BIT) bits. Cleared on every state transition, otherwise +1.
  - bit_idx: 0..DATA_BITS-1.
- FSM states:
  - IDLE: line_s=0 -> START, cell_cnt=0.
  - START:
    - At cell_cnt==HALF_BIT-1, sample line_s.
    - 0 -> DATA, bit_idx=0. 1 -> IDLE (glitch rejected, no flag).
  - DATA:
    - At cell_cnt==CLKS_PER_BIT-1, shift line_s into shreg MSB; shreg shifts right.
    - bit_idx==DATA_BITS-1 -> STOP (or PARITY when enabled), else bit_idx+1.
  - STOP: at cell_cnt==CLKS_PER_BIT-1, sample line_s, then go to IDLE in the same cycle.
    - 1: push shreg to buffer.
    - 0: frame_errH=1 for that cycle, byte discarded.
  - Next start edge is accepted from IDLE immediately, mid-stop-bit onwards. Back-to-back frames must work with zero idle time.
- Buffer:
  - 2-entry FIFO with 2-bit count.
  - Push and pop in the same cycle are both honoured. When count==2, pop-and-push in the same cycle is not an overrun.
  - Push when count==2 and no pop: byte dropped, overrunH pulse, buffer contents unchanged.
  - rx_dataH is registered from the head entry and holds stable while rx_validH=1 and rx_readyH=0.
- Latency: rx_validH rises 1 cycle after the stop-bit sample cycle.
- frame_errH and overrunH never assert in the same cycle.
- Default FSM branch returns to IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP; samples one even-parity bit at cell_cnt==CLKS_PER_BIT-1.
  - Extra output parity_errH, a one-cycle pulse in the stop-sample cycle when parity mismatches. The byte is discarded.
  - If the stop bit is also 0, only frame_errH fires.
- Undefined: no PARITY state, no parity_errH port; the frame is 1+DATA_BITS+1 bits.

Test Plan:
- Reset, line idle 1, 200 cycles -> rx_validH=0, busyH=0, no pulses.
- Frame 0xA5 at 16 clk/bit, rx_readyH=1 -> rx_dataH=0xA5, rx_validH high exactly 1 cycle, rising 1 cycle after stop sample; no error flags.
- Line pulled low for 5 cycles then back to 1 -> START rejects at HALF_BIT sample, busyH returns 0, no valid/error.
- Frame 0x3C with stop bit forced 0 -> frame_errH single pulse, buffer still empty.
- rx_readyH=0; frames 0x11, 0x22, 0x33 back-to-back -> 0x11, 0x22 held; overrunH pulses at 0x33 stop; then rx_readyH=1 pops 0x11 then 0x22.
- UART_RX_PARITY_EN: frame 0x07 sent with parity bit 0 -> parity_errH pulse, no push. Frame 0x07 with parity 1 -> rx_dataH=0x07.

Source files
------------

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - 8N1 UART frame receiver with a 2-entry byte buffer
// Define UART_RX_PARITY_EN to add an even-parity bit before stop and the parity_errH output.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rx_dataH,
  output logic [DATA_BITS-1:0] rx_dataH,
  output logic                 rx_validH,
  input  logic                 rx_readyH,
  output logic                 frame_errH,
  output logic                 overrunH,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_errH,
`endif
  output logic                 busyH
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 sync1, line_s;
  logic [CW-1:0]        cell_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] entry1;
  logic [1:0]           count;
  logic                 shift_en, cnt_wrap, stop_sample;
  logic                 stop_ok, push, push_acc, pop;
`ifdef UART_RX_PARITY_EN
  logic                 par_en, par_bit, par_ok;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    shift_en    = 1'b0;
    cnt_wrap    = 1'b0;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
`endif
    case (state)
      IDLE:  if (!line_s) state_nxt = START;
      START: if (cell_cnt == HALF_LAST) state_nxt = line_s ? IDLE : DATA;
      DATA: begin
        if (cell_cnt == CELL_LAST) begin
          shift_en = 1'b1;
          cnt_wrap = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == BIT_LAST) state_nxt = PARITY;
`else
          if (bit_idx == BIT_LAST) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cell_cnt == CELL_LAST) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (cell_cnt == CELL_LAST) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cell_cnt restarts on every state change and at each data-cell boundary
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1    <= 1'b1;
      line_s   <= 1'b1;
      cell_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      sync1  <= uart_rx_dataH;
      line_s <= sync1;
      if ((state_nxt != state) || cnt_wrap) cell_cnt <= '0;
      else                                  cell_cnt <= cell_cnt + 1'b1;
      if (state == START)  bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {line_s, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)     par_bit <= 1'b0;
    else if (par_en) par_bit <= line_s;
  end
  assign par_ok      = ((^shreg) == par_bit);
  assign parity_errH = stop_ok & ~par_ok;
  assign push        = stop_ok & par_ok;
`else
  assign push        = stop_ok;
`endif

  assign stop_ok    = stop_sample & line_s & ~sys_rst;
  assign frame_errH = stop_sample & ~line_s & ~sys_rst;
  assign pop        = rx_validH & rx_readyH;
  assign overrunH   = push & (count == 2'd2) & ~pop;
  assign push_acc   = push & ~overrunH;
  assign rx_validH  = (count != 2'd0);
  assign busyH      = (state != IDLE);

  // rx_dataH is the head register itself; entry1 is the second slot
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_dataH <= '0;
      entry1   <= '0;
      count    <= 2'd0;
    end else begin
      if (pop && (count == 2'd2)) begin
        rx_dataH <= entry1;
        if (push_acc) entry1 <= shreg;
      end else if (push_acc) begin
        if ((count == 2'd0) || pop) rx_dataH <= shreg;
        else                        entry1   <= shreg;
      end
      count <= count + {1'b0, push_acc} - {1'b0, pop};
    end
  end
endmodule
